// File: rtl/mdu_unit.sv
// mdu_unit: iterative radix-2 multiply/divide unit with start/busy/done handshake.
// Produces a 2*WIDTH-bit HI/LO result; one step per cycle over WIDTH cycles.
// Optional feature macro: MDU_DIV_EN (when undefined the divider datapath is
// omitted and divide ops complete in one cycle with err=1, hi/lo unchanged).
module mdu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

  // Magnitude of an operand; unsigned ops pass the raw bits through.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic signed_op);
    magnitude = (signed_op && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     a_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic                 neg_lo_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic                 sign_a_d;
  logic                 sign_b_d;
  logic [WIDTH-1:0]     mag_a_d;
  logic [WIDTH-1:0]     mag_b_d;
  logic [WIDTH:0]       mul_sum_d;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   prod_d;
  logic [WIDTH-1:0]     res_hi_d;
  logic [WIDTH-1:0]     res_lo_d;

`ifdef MDU_DIV_EN
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     rem_q;
  logic                 is_div_q;
  logic                 neg_hi_q;
  logic [WIDTH:0]       rem_sh_d;
  logic [WIDTH:0]       diff_d;
  logic                 ge_d;
  logic [WIDTH-1:0]     rem_d;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Operand conditioning, one iteration step and final sign fix-up.
  always_comb begin
    sign_a_d  = ~op[0] & opA[WIDTH-1];
    sign_b_d  = ~op[0] & opB[WIDTH-1];
    mag_a_d   = magnitude(opA, ~op[0]);
    mag_b_d   = magnitude(opB, ~op[0]);

    // Multiply: add multiplicand into the upper half when the multiplier LSB
    // is set, then shift the whole accumulator right by one.
    mul_sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                ({1'b0, a_q} & {(WIDTH+1){acc_q[0]}});
    acc_d     = {mul_sum_d, acc_q[WIDTH-1:1]};

    prod_d    = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
    res_hi_d  = prod_d[2*WIDTH-1:WIDTH];
    res_lo_d  = prod_d[WIDTH-1:0];

`ifdef MDU_DIV_EN
    // Divide: the dividend shifts out of acc_q[WIDTH-1:0] MSB-first while
    // quotient bits shift in at the bottom (restoring algorithm).
    rem_sh_d  = {rem_q, acc_q[WIDTH-1]};
    diff_d    = rem_sh_d - {1'b0, b_q};
    ge_d      = ~diff_d[WIDTH];
    rem_d     = ge_d ? diff_d[WIDTH-1:0] : rem_sh_d[WIDTH-1:0];
    if (is_div_q) begin
      acc_d    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ge_d};
      res_lo_d = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
      res_hi_d = neg_hi_q ? (~rem_q + 1'b1) : rem_q;
    end
`endif
  end

  // Control FSM with registered handshake outputs and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      acc_q    <= '0;
      neg_lo_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MDU_DIV_EN
      b_q      <= '0;
      rem_q    <= '0;
      is_div_q <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
          if (start) begin
            cnt_q <= '0;
            err_q <= 1'b0;
`ifdef MDU_DIV_EN
            if (op[1] && (opB == '0)) begin
              // Divide by zero finishes immediately without entering CALC.
              err_q   <= 1'b1;
              hi_q    <= opA;
              lo_q    <= '1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              a_q      <= mag_a_d;
              b_q      <= mag_b_d;
              acc_q    <= {{WIDTH{1'b0}}, (op[1] ? mag_a_d : mag_b_d)};
              rem_q    <= '0;
              is_div_q <= op[1];
              neg_lo_q <= sign_a_d ^ sign_b_d;
              neg_hi_q <= sign_a_d;
              busy_q   <= 1'b1;
              state_q  <= S_CALC;
            end
`else
            if (op[1]) begin
              // No divider: flag the op and leave hi/lo untouched.
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              a_q      <= mag_a_d;
              acc_q    <= {{WIDTH{1'b0}}, mag_b_d};
              neg_lo_q <= sign_a_d ^ sign_b_d;
              busy_q   <= 1'b1;
              state_q  <= S_CALC;
            end
`endif
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
`ifdef MDU_DIV_EN
          if (is_div_q) rem_q <= rem_d;
`endif
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_q <= S_SIGN;
        end
        S_SIGN: begin
          hi_q    <= res_hi_d;
          lo_q    <= res_lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed self-checking bench for mdu_unit.
module tb_mdu_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        err;

  int ncmp;
  int nerr;
  int lat;
  int ndone;

  mdu_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .opA   (opA),
    .opB   (opB),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    opA   = a;
    opB   = b;
    tick();
    start = 1'b0;
  endtask

  // Edges after the acceptance edge until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    ncmp  = 0;
    nerr  = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    opA   = '0;
    opB   = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err",  32'(err),  32'd0);
    check("rst_hi",   hi, 32'd0);
    check("rst_lo",   lo, 32'd0);
    rst_n = 1'b1;
    tick();

    // MULTU all ones
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_busy", 32'(busy), 32'd1);
    check("multu_done0", 32'(done), 32'd0);
    wait_done(lat);
    check("multu_lat", 32'(lat), 32'd33);
    check("multu_busy_at_done", 32'(busy), 32'd0);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);
    check("multu_err", 32'(err), 32'd0);
    tick();
    check("multu_done_fall", 32'(done), 32'd0);

    // MULT -7 * 6, operands disturbed after acceptance
    issue(2'b00, 32'hFFFFFFF9, 32'd6);
    opA = 32'd12345;
    opB = 32'd99;
    wait_done(lat);
    check("mult_lat", 32'(lat), 32'd33);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFD6);
    tick();

    // MULT -2^31 * -2^31 = 2^62
    issue(2'b00, 32'h80000000, 32'h80000000);
    wait_done(lat);
    check("mult_min2_hi", hi, 32'h40000000);
    check("mult_min2_lo", lo, 32'h00000000);
    tick();

    // MULT -2^31 * 1
    issue(2'b00, 32'h80000000, 32'd1);
    wait_done(lat);
    check("mult_min1_hi", hi, 32'hFFFFFFFF);
    check("mult_min1_lo", lo, 32'h80000000);
    tick();

    // Back-to-back: start held high through the first op
    start = 1'b1;
    op    = 2'b01;
    opA   = 32'd3;
    opB   = 32'd5;
    tick();
    wait_done(lat);
    check("b2b1_lat", 32'(lat), 32'd33);
    check("b2b1_lo", lo, 32'd15);
    check("b2b1_hi", hi, 32'd0);
    opA = 32'd7;
    opB = 32'd9;
    tick();
    start = 1'b0;
    check("b2b2_busy", 32'(busy), 32'd1);
    check("b2b2_done", 32'(done), 32'd0);
    wait_done(lat);
    check("b2b2_lat", 32'(lat), 32'd33);
    check("b2b2_lo", lo, 32'd63);
    tick();

    // Start pulsed during CALC is ignored
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (5) tick();
    start = 1'b1;
    op    = 2'b01;
    opA   = 32'd2;
    opB   = 32'd2;
    tick();
    start = 1'b0;
    lat = 6;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    check("ign_lat", 32'(lat), 32'd33);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd1);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    check("ign_extra_done", 32'(ndone), 32'd0);

`ifdef MDU_DIV_EN
    issue(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done(lat);
    check("div_lat", 32'(lat), 32'd33);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    check("div_err", 32'(err), 32'd0);
    tick();

    issue(2'b11, 32'd100, 32'd7);
    wait_done(lat);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    tick();

    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat);
    check("divovf_lo", lo, 32'h80000000);
    check("divovf_hi", hi, 32'd0);
    check("divovf_err", 32'(err), 32'd0);
    tick();

    issue(2'b10, 32'd7, 32'hFFFFFFFE);
    wait_done(lat);
    check("divneg_lo", lo, 32'hFFFFFFFD);
    check("divneg_hi", hi, 32'd1);
    tick();

    issue(2'b11, 32'd5, 32'd0);
    check("dz_done", 32'(done), 32'd1);
    check("dz_busy", 32'(busy), 32'd0);
    check("dz_err", 32'(err), 32'd1);
    check("dz_hi", hi, 32'd5);
    check("dz_lo", lo, 32'hFFFFFFFF);
    tick();
    check("dz_done_fall", 32'(done), 32'd0);
`else
    issue(2'b10, 32'hFFFFFFF9, 32'd2);
    check("nodiv_done", 32'(done), 32'd1);
    check("nodiv_busy", 32'(busy), 32'd0);
    check("nodiv_err", 32'(err), 32'd1);
    check("nodiv_hi", hi, 32'd0);
    check("nodiv_lo", lo, 32'd1);
    tick();
    check("nodiv_done_fall", 32'(done), 32'd0);
`endif

    // Error flag clears on the next accepted op
    issue(2'b01, 32'd2, 32'd3);
    wait_done(lat);
    check("clr_err", 32'(err), 32'd0);
    check("clr_lo", lo, 32'd6);
    tick();

    // Reset at cycle 10 of a MULT
    issue(2'b00, 32'h00001234, 32'h00000010);
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    check("midrst_lo_kept", lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
